led_strip_driver: RTL and testbench

LED_STRIP_DRIVER -- requirements
Module: led_strip_driver

---
 rtl/led_strip_driver.sv | 121 ++++++++++++
 tb/tb_led_strip_driver.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_strip_driver.sv
// WS2812-style serial LED strip driver: fetches GRB bytes per LED index,
// shifts them out as timed high/low pulses, then holds a latch gap.
module led_strip_driver #(
    parameter int MAX_POS      = 109,
    parameter int BIT_CYCLES   = 63,
    parameter int T0H_CYCLES   = 20,
    parameter int T1H_CYCLES   = 40,
    parameter int RESET_CYCLES = 2600,
    localparam int LW   = (MAX_POS > 1) ? $clog2(MAX_POS) : 1,
    localparam int CMAX = (BIT_CYCLES > RESET_CYCLES) ? BIT_CYCLES : RESET_CYCLES,
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic [7:0]    led_green_intensity,
    input  logic [7:0]    led_red_intensity,
    input  logic [7:0]    led_blue_intensity,
    output logic [LW-1:0] current_led,
    output logic          data_out,
    output logic          busy,
    output logic          frame_done
);

    localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] RST_LAST = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] T0H_C    = CW'(T0H_CYCLES);
    localparam logic [CW-1:0] T1H_C    = CW'(T1H_CYCLES);
    localparam logic [LW-1:0] LED_LAST = LW'(MAX_POS - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND,
        LATCH
    } state_t;

    state_t        state, state_n;
    logic [23:0]   shreg, shreg_n;
    logic [4:0]    bit_idx, bit_idx_n;
    logic [CW-1:0] cyc, cyc_n;
    logic [LW-1:0] led_n;
    logic          data_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            shreg       <= '0;
            bit_idx     <= '0;
            cyc         <= '0;
            current_led <= '0;
            data_out    <= 1'b0;
        end else begin
            state       <= state_n;
            shreg       <= shreg_n;
            bit_idx     <= bit_idx_n;
            cyc         <= cyc_n;
            current_led <= led_n;
            data_out    <= data_n;
        end
    end

    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        bit_idx_n = bit_idx;
        cyc_n     = cyc;
        led_n     = current_led;
        unique case (state)
            IDLE: begin
                led_n = '0;
                if (enable)
                    state_n = LOAD;
            end
            LOAD: begin
                shreg_n   = {led_green_intensity, led_red_intensity,
                             led_blue_intensity};
                bit_idx_n = '0;
                cyc_n     = '0;
                state_n   = SEND;
            end
            SEND: begin
                if (cyc == BIT_LAST) begin
                    cyc_n = '0;
                    if (bit_idx == 5'd23) begin
                        bit_idx_n = '0;
                        if (current_led == LED_LAST) begin
                            led_n   = '0;
                            state_n = LATCH;
                        end else begin
                            led_n   = current_led + 1'b1;
                            state_n = LOAD;
                        end
                    end else begin
                        bit_idx_n = bit_idx + 5'd1;
                        shreg_n   = {shreg[22:0], 1'b0};
                    end
                end else begin
                    cyc_n = cyc + 1'b1;
                end
            end
            LATCH: begin
                if (cyc == RST_LAST) begin
                    cyc_n   = '0;
                    state_n = enable ? LOAD : IDLE;
                end else begin
                    cyc_n = cyc + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        // Derived from next-state values so the line is registered yet
        // the first high phase lines up with the cycle after LOAD.
        data_n = (state_n == SEND) &&
                 (cyc_n < (shreg_n[23] ? T1H_C : T0H_C));
    end

    assign busy       = (state != IDLE);
    assign frame_done = (state == LATCH) && (cyc == RST_LAST);

endmodule

// File: tb/tb_led_strip_driver.sv
// Bench for led_strip_driver: frame-timeline model checked every cycle,
// plus decoded-bit and timing literals for the directed scenarios.
module tb_led_strip_driver;

    localparam int NL = 3;
    localparam int BC = 10;
    localparam int T0 = 3;
    localparam int T1 = 7;
    localparam int RC = 20;
    localparam int S  = 1 + 24 * BC;
    localparam int F  = NL * S + RC;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [7:0] led_g, led_r, led_b;
    logic [1:0] current_led;
    logic       data_out, busy, frame_done;

    logic [7:0] tbl_g[NL];
    logic [7:0] tbl_r[NL];
    logic [7:0] tbl_b[NL];

    int passed = 0;
    int total  = 0;

    led_strip_driver #(
        .MAX_POS(NL), .BIT_CYCLES(BC), .T0H_CYCLES(T0),
        .T1H_CYCLES(T1), .RESET_CYCLES(RC)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .led_green_intensity(led_g),
        .led_red_intensity(led_r),
        .led_blue_intensity(led_b),
        .current_led(current_led), .data_out(data_out),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    assign led_g = (current_led < 2'd3) ? tbl_g[current_led] : 8'h00;
    assign led_r = (current_led < 2'd3) ? tbl_r[current_led] : 8'h00;
    assign led_b = (current_led < 2'd3) ? tbl_b[current_led] : 8'h00;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // Frame-timeline model: m_t is the cycle offset from the first LOAD.
    logic        m_active = 1'b0;
    int          m_t = 0;
    logic [23:0] m_col[NL];

    always @(posedge clk) begin
        if (rst) begin
            m_active <= 1'b0;
            m_t      <= 0;
        end else if (!m_active) begin
            if (enable) begin
                m_active <= 1'b1;
                m_t      <= 0;
            end
        end else begin
            if (m_t < NL * S && m_t % S == 0)
                m_col[m_t / S] <= {tbl_g[m_t / S], tbl_r[m_t / S], tbl_b[m_t / S]};
            if (m_t == F - 1) begin
                if (enable) m_t <= 0;
                else m_active <= 1'b0;
            end else begin
                m_t <= m_t + 1;
            end
        end
    end

    always @(negedge clk) begin
        int e_o, e_led, e_busy, e_fd, led, o, b, c;
        if (rst) begin
            chk("rst_data_out", int'(data_out), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_led", int'(current_led), 0);
            chk("rst_frame_done", int'(frame_done), 0);
        end else begin
            e_o = 0; e_led = 0; e_busy = 0; e_fd = 0;
            if (m_active) begin
                e_busy = 1;
                if (m_t < NL * S) begin
                    led   = m_t / S;
                    o     = m_t % S;
                    e_led = led;
                    if (o != 0) begin
                        b   = (o - 1) / BC;
                        c   = (o - 1) % BC;
                        e_o = (c < (m_col[led][23 - b] ? T1 : T0)) ? 1 : 0;
                    end
                end else begin
                    e_fd = (m_t == F - 1) ? 1 : 0;
                end
            end
            chk("data_out", int'(data_out), e_o);
            chk("current_led", int'(current_led), e_led);
            chk("busy", int'(busy), e_busy);
            chk("frame_done", int'(frame_done), e_fd);
        end
    end

    // Pulse decoder: each high run becomes one bit (long run = 1).
    logic dec_bits[$];
    int   dec_lens[$];
    int   hi_len = 0;
    int   rises  = 0;

    always @(negedge clk) begin
        if (rst) begin
            hi_len = 0;
        end else if (data_out) begin
            if (hi_len == 0) rises++;
            hi_len++;
        end else if (hi_len > 0) begin
            dec_bits.push_back(hi_len >= 5);
            dec_lens.push_back(hi_len);
            hi_len = 0;
        end
    end

    function automatic logic [23:0] pack(input int start);
        logic [23:0] v = '0;
        for (int i = 0; i < 24; i++) v = {v[22:0], dec_bits[start + i]};
        return v;
    endfunction

    function automatic int bad_lens(input int start, input int n);
        int bad = 0;
        for (int i = start; i < start + n; i++)
            if (dec_lens[i] != (dec_bits[i] ? T1 : T0)) bad++;
        return bad;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_fd(input string nm);
        int n = 0;
        while (!frame_done && n < 2 * F) begin tick(); n++; end
        chk(nm, int'(frame_done), 1);
    endtask

    task automatic wait_led(input int v, input string nm);
        int n = 0;
        while (int'(current_led) != v && n < 2 * F) begin tick(); n++; end
        chk(nm, int'(current_led), v);
    endtask

    task automatic set_tbl();
        tbl_g[0] = 8'hA5; tbl_r[0] = 8'h00; tbl_b[0] = 8'hFF;
        tbl_g[1] = 8'h3C; tbl_r[1] = 8'hC3; tbl_b[1] = 8'h01;
        tbl_g[2] = 8'h80; tbl_r[2] = 8'h7E; tbl_b[2] = 8'h55;
    endtask

    task automatic check_frame(input int base, input string nm);
        chk({nm, "_nbits"}, dec_bits.size() - base, 72);
        chk({nm, "_led0"}, int'(pack(base)), 24'hA500FF);
        chk({nm, "_led1"}, int'(pack(base + 24)), 24'h3CC301);
        chk({nm, "_led2"}, int'(pack(base + 48)), 24'h807E55);
        chk({nm, "_widths"}, bad_lens(base, 72), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base, r0, n;
        int fd_t[$];
        int seq[$];
        set_tbl();
        enable = 1'b0;
        rst    = 1'b0;
        #2 rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("idle_busy", int'(busy), 0);

        // Single frame from a one-cycle enable pulse
        base = dec_bits.size();
        enable = 1'b1; tick(); enable = 1'b0;
        wait_fd("t1_fd");
        tick(); tick();
        check_frame(base, "t1");
        chk("t1_idle_busy", int'(busy), 0);
        chk("t1_idle_led", int'(current_led), 0);

        // Index sweep and frame period with enable held
        enable = 1'b1;
        seq.push_back(int'(current_led));
        n = 0;
        while (fd_t.size() < 3 && n < 4 * F) begin
            tick(); n++;
            if (int'(current_led) != seq[seq.size() - 1])
                seq.push_back(int'(current_led));
            if (frame_done) fd_t.push_back(n);
        end
        enable = 1'b0;
        chk("t2_fd_count", fd_t.size(), 3);
        chk("t2_period1", fd_t[1] - fd_t[0], 743);
        chk("t2_period2", fd_t[2] - fd_t[1], 743);
        chk("t2_seq1", seq[1], 1);
        chk("t2_seq2", seq[2], 2);
        chk("t2_seq3", seq[3], 0);
        tick();
        chk("t2_idle", int'(busy), 0);

        // Input change mid-SEND of LED1 must not reach LED1
        base = dec_bits.size();
        enable = 1'b1; tick(); enable = 1'b0;
        wait_led(1, "t3_led1");
        repeat (30) tick();
        tbl_g[1] = 8'h11; tbl_r[1] = 8'h22; tbl_b[1] = 8'h33;
        wait_fd("t3_fd");
        tick();
        check_frame(base, "t3");
        set_tbl();
        tick();

        // Enable dropped during LED1: frame still completes
        base = dec_bits.size();
        enable = 1'b1;
        wait_led(1, "t4_led1");
        enable = 1'b0;
        wait_fd("t4_fd");
        tick(); tick();
        check_frame(base, "t4");
        chk("t4_busy", int'(busy), 0);
        chk("t4_led", int'(current_led), 0);

        // Reset during the high phase of LED0 bit 5
        r0 = rises;
        enable = 1'b1; tick(); enable = 1'b0;
        n = 0;
        while (rises < r0 + 6 && n < 2 * S) begin tick(); n++; end
        chk("t5_pre_high", int'(data_out), 1);
        rst = 1'b1;
        #1;
        chk("t5_rst_data", int'(data_out), 0);
        chk("t5_rst_busy", int'(busy), 0);
        chk("t5_rst_led", int'(current_led), 0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (4) tick();
        chk("t5_stay_idle", int'(busy), 0);
        base = dec_bits.size();
        enable = 1'b1; tick(); enable = 1'b0;
        wait_fd("t5_fd");
        tick(); tick();
        check_frame(base, "t5");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
